float_accum_ctrl: RTL and testbench
===================================

FLOAT_ACCUM_CTRL -- requirements
Module: float_accum_ctrl

Interface
REQ-001 Parameter: LEN_W, default 8, width of the element-count input.
REQ-002 Parameter: DATA_W, default 32, IEEE-754 single-precision word width; only 32 is supported.
REQ-003 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port: reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-005 Port: start  input  1  one-cycle request to begin a new accumulation; honoured only in IDLE.
REQ-006 Port: len  input  LEN_W  number of elements to sum; sampled when start is accepted.
REQ-007 Port: abort  input  1  cancels the job in progress and returns the block to IDLE.
REQ-008 Port: in_valid  input  1  in_data holds a valid operand.
REQ-009 Port: in_data  input  DATA_W  operand in IEEE-754 single-precision format.
REQ-010 Port: in_ready  output  1  the block accepts an operand this cycle.
REQ-011 Port: sum_out  output  DATA_W  accumulated result.
REQ-012 Port: out_valid  output  1  sum_out is valid.
REQ-013 Port: out_ready  input  1  the consumer accepts sum_out.
REQ-014 Port: busy  output  1  high in every state except IDLE.

Function
REQ-015 The block SHALL instantiate exactly one floatAdd, with floatA = acc register, floatB = in_data, and sum feeding acc; no other adder is permitted.
REQ-016 The FSM SHALL have exactly three states: IDLE, ACCUM and DONE.
REQ-017 IDLE: in_ready=0 and out_valid=0; on start with len!=0, the block SHALL set acc=32'h00000000 and cnt=len, and move to ACCUM.
REQ-018 IDLE: on start with len==0, the block SHALL set acc=32'h00000000 and move directly to DONE.
REQ-019 ACCUM: in_ready=1; an operand is accepted when in_valid && in_ready.
- On acceptance, acc <= floatAdd(acc, in_data) and cnt <= cnt-1.
REQ-020 ACCUM: an acceptance while cnt==1 SHALL move the FSM to DONE on the same edge; the final acc is visible one cycle after the last acceptance.
REQ-021 ACCUM: cycles with in_valid=0 SHALL hold acc and cnt unchanged; there is no timeout.
REQ-022 DONE: out_valid=1 and sum_out=acc; in_ready=0.
- On out_ready=1, the FSM SHALL return to IDLE on the next edge.
- sum_out SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 sum_out SHALL equal acc in every state and is meaningful only while out_valid=1.
REQ-024 start asserted in ACCUM or DONE SHALL be ignored and SHALL NOT alter len, cnt or acc.
REQ-025 abort in ACCUM or DONE SHALL force IDLE on the next edge, with acc=0 and cnt=0 and no out_valid pulse.
- abort has priority over an operand acceptance and over out_ready in the same cycle.
- abort in IDLE has no effect, and start is ignored in any cycle where abort=1.
REQ-026 Throughput SHALL be one operand per clock; per-job latency from start to out_valid SHALL be len+1 cycles when in_valid is held high.
REQ-027 cnt SHALL be LEN_W bits wide and SHALL never wrap, because the DONE transition at cnt==1 precludes a decrement from 0.
REQ-028 The block SHALL NOT interpret NaN, Inf or denormal values; arithmetic results are exactly those produced by floatAdd.

Reset
REQ-029 While reset=0 at a clock edge, the block SHALL load state=IDLE, acc=0 and cnt=0.
- Outputs then read in_ready=0, out_valid=0, busy=0 and sum_out=32'h00000000.
REQ-030 Reset asserted mid-job (ACCUM or DONE) SHALL discard the job without emitting out_valid.
REQ-031 On the first edge with reset=1, start is honoured normally.

Verification
REQ-032 start, len=3, operands 3F800000, 40000000, 40400000 on consecutive cycles -> out_valid on cycle 4 with sum_out=40C00000 (6.0).
REQ-033 start, len=2, operands 3F800000 and C0000000 with one idle in_valid=0 cycle between them -> sum_out=BF800000 (-1.0) and acc held during the gap.
REQ-034 start with len=0 -> out_valid on the next cycle with sum_out=00000000 and in_ready never high.
REQ-035 In DONE, out_ready held low for 5 cycles -> sum_out stable; a start pulse during that time is ignored; out_ready=1 -> IDLE and busy=0.
REQ-036 start with len=4, abort after 2 operands -> IDLE with no out_valid; a following job with len=1 and operand 3F000000 -> sum_out=3F000000 (acc cleared).
REQ-037 reset=0 asserted for one cycle in ACCUM -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/float_accum_ctrl.sv
// Streaming single-precision accumulator: sums len operands through one
// combinational floatAdd, then holds the result until the consumer takes it.

module floatAdd (
  input  logic [31:0] floatA,
  input  logic [31:0] floatB,
  output logic [31:0] sum
);
  logic [31:0]       big, sml;
  logic [7:0]        d;
  logic [26:0]       mb, ms, ms_sh, norm;
  logic [27:0]       tmp;
  logic [4:0]        lz;
  logic signed [9:0] e;
  logic [24:0]       rnd;
  logic [22:0]       man;
  logic              up, same, zsign;

  always_comb begin
    // Order by magnitude so the subtract path never goes negative.
    if (floatA[30:0] >= floatB[30:0]) begin
      big = floatA;
      sml = floatB;
    end else begin
      big = floatB;
      sml = floatA;
    end
    same  = (big[31] == sml[31]);
    zsign = same & big[31];
    d     = big[30:23] - sml[30:23];
    mb    = {|big[30:23], big[22:0], 3'b000};
    ms    = {|sml[30:23], sml[22:0], 3'b000};
    // Align the smaller operand, folding shifted-out bits into a sticky bit.
    if (d >= 8'd27)
      ms_sh = {26'd0, |ms};
    else
      ms_sh = (ms >> d) | {26'd0, |(ms & ((27'd1 << d) - 27'd1))};
    e  = $signed({2'b00, big[30:23]});
    lz = 5'd27;
    if (same) begin
      tmp = {1'b0, mb} + {1'b0, ms_sh};
      if (tmp[27]) begin
        norm = {tmp[27:2], tmp[1] | tmp[0]};
        e    = e + 10'sd1;
      end else begin
        norm = tmp[26:0];
      end
      lz = 5'd0;
    end else begin
      tmp = {1'b0, mb - ms_sh};
      for (int i = 0; i < 27; i++)
        if (tmp[i]) lz = 5'(26 - i);
      norm = tmp[26:0] << lz;
      e    = e - $signed({5'd0, lz});
    end
    // Round to nearest, ties to even.
    up  = norm[2] & (norm[3] | norm[1] | norm[0]);
    rnd = {1'b0, norm[26:3]} + {24'd0, up};
    if (rnd[24]) begin
      e   = e + 10'sd1;
      man = rnd[23:1];
    end else begin
      man = rnd[22:0];
    end
    if (!norm[26])
      sum = {zsign, 31'd0};
    else if (e <= 10'sd0)
      sum = {big[31], 31'd0};
    else if (e >= 10'sd255)
      sum = {big[31], 8'hFF, 23'd0};
    else
      sum = {big[31], e[7:0], man};
  end
endmodule

module float_accum_ctrl #(
  parameter int LEN_W  = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] sum_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] acc, add_sum;
  logic [LEN_W-1:0]  cnt;
  logic              accept, go;

  floatAdd u_add (
    .floatA(acc),
    .floatB(in_data),
    .sum   (add_sum)
  );

  assign accept  = in_valid & in_ready;
  assign go      = start & ~abort;
  assign sum_out = acc;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (go) state_nx = (len == '0) ? DONE : ACCUM;
      ACCUM:   if (abort) state_nx = IDLE;
               else if (accept && cnt == LEN_W'(1)) state_nx = DONE;
      DONE:    if (abort || out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ACCUM);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // acc is left intact on DONE->IDLE so sum_out keeps the last result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (go) begin
          acc <= '0;
          cnt <= len;
        end
        ACCUM: if (abort) begin
          acc <= '0;
          cnt <= '0;
        end else if (accept) begin
          acc <= add_sum;
          cnt <= cnt - LEN_W'(1);
        end
        DONE: if (abort) begin
          acc <= '0;
          cnt <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_float_accum_ctrl.sv
// Randomized bench for float_accum_ctrl: real-arithmetic reference model,
// expected sums queued at job start and checked by an independent monitor.

module tb_float_accum_ctrl;
  localparam int LW = 8;

  logic          clk = 0, reset = 0, start = 0, abort = 0;
  logic [LW-1:0] len = '0;
  logic          in_valid = 0, out_ready = 0;
  logic [31:0]   in_data = '0;
  logic          in_ready, out_valid, busy;
  logic [31:0]   sum_out;

  int            errors = 0, checks = 0;
  logic [31:0]   exp_q[$];
  logic [31:0]   last_out = '0;
  real           vq[$];

  float_accum_ctrl #(.LEN_W(LW), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .sum_out(sum_out), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Exact-value conversion; stimulus keeps all sums exactly representable.
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] b;
    int          e;
    if (r == 0.0) return 32'h0;
    b = $realtobits(r);
    e = int'(b[62:52]) - 1023 + 127;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every handshake and checks hold stability.
  logic        pv = 0, pr = 0, pab = 0, prst = 0;
  logic [31:0] ps = '0;
  always @(negedge clk) begin
    logic [31:0] e;
    if (prst && reset && pv && !pr && !pab) begin
      checks++;
      if (!out_valid || sum_out !== ps) begin
        errors++;
        $display("FAIL done_hold: out_valid=%0b sum_out=%h required 1/%h", out_valid, sum_out, ps);
      end
    end
    if (reset && out_valid && out_ready && !abort) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: sum_out=%h with no job pending", sum_out);
      end else begin
        e = exp_q.pop_front();
        last_out = sum_out;
        if (sum_out !== e) begin
          errors++;
          $display("FAIL sum: got %h required %h", sum_out, e);
        end
      end
    end
    pv = out_valid; pr = out_ready; pab = abort; prst = reset; ps = sum_out;
  end

  // Runs one job over vq; returns cycles from start to out_valid.
  task automatic job(input int gap_pct, input int fixed_gap, input int hold,
                     input bit start_in_done, input bit noise, output int lat);
    int  n, idx, cyc, gap_left;
    real s;
    bit  acc_ok, in_gap;
    n = vq.size(); idx = 0; cyc = 0; gap_left = 0; s = 0.0;
    foreach (vq[i]) s += vq[i];
    exp_q.push_back(r2f(s));
    start = 1; len = LW'(n); in_valid = 0;
    tick;
    start = 0; cyc = 1;
    while (!out_valid && cyc < 1000) begin
      in_gap = 0;
      if (gap_left > 0) begin
        in_valid = 0; gap_left--; in_gap = 1;
      end else begin
        in_valid = (idx < n) && ($urandom_range(99) >= gap_pct);
      end
      in_data = (idx < n) ? r2f(vq[idx]) : $urandom;
      if (noise) begin
        start = ($urandom_range(9) == 0);
        len   = LW'($urandom_range(20));
      end
      if (n == 0 && in_ready) chk("len0_in_ready", {31'd0, in_ready}, 32'd0);
      if (in_gap) chk("gap_hold", sum_out, r2f(vq[0]));
      acc_ok = in_valid && in_ready;
      tick;
      if (acc_ok) begin
        idx++;
        if (idx == 1) gap_left = fixed_gap;
      end
      cyc++;
    end
    in_valid = 0; start = 0;
    lat = cyc;
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL timeout: out_valid=0 after %0d cycles required 1", cyc);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1);
    end
    chk("ops_consumed", idx, n);
    for (int k = 0; k < hold; k++) begin
      start = start_in_done && (k == 2);
      len = LW'(3);
      tick;
    end
    start = 0;
    out_ready = 1;
    tick;
    out_ready = 0;
    chk("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int lat, n;
    // reset state
    repeat (3) tick;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sum", sum_out, 32'h0);
    reset = 1;

    // 1+2+3, back-to-back operands
    vq.delete(); vq.push_back(1.0); vq.push_back(2.0); vq.push_back(3.0);
    job(0, 0, 0, 0, 0, lat);
    chk("lat_len3", lat, 4);
    chk("sum_6", last_out, 32'h40C00000);

    // 1 + (-2) with one idle cycle in between
    vq.delete(); vq.push_back(1.0); vq.push_back(-2.0);
    job(0, 1, 0, 0, 0, lat);
    chk("sum_m1", last_out, 32'hBF800000);

    // empty job
    vq.delete();
    job(0, 0, 0, 0, 0, lat);
    chk("lat_len0", lat, 1);
    chk("sum_len0", last_out, 32'h0);

    // consumer stalls 5 cycles, start pulse in DONE ignored
    vq.delete(); vq.push_back(2.5); vq.push_back(4.0);
    job(0, 0, 5, 1, 0, lat);
    chk("stall_sum", last_out, r2f(6.5));
    tick;
    chk("stall_no_restart", {31'd0, busy}, 32'd0);

    // abort after two operands (abort wins over a concurrent operand)
    start = 1; len = LW'(4); tick; start = 0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1; in_data = 32'h3F800000; tick;
    end
    abort = 1; in_valid = 1; tick;
    abort = 0; in_valid = 0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_acc", sum_out, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_out", {31'd0, out_valid}, 32'd0);
      tick;
    end
    vq.delete(); vq.push_back(0.5);
    job(0, 0, 0, 0, 0, lat);
    chk("after_abort", last_out, 32'h3F000000);

    // abort in DONE beats out_ready
    start = 1; len = LW'(1); tick; start = 0;
    in_valid = 1; in_data = 32'h40000000; tick; in_valid = 0;
    chk("done_reached", {31'd0, out_valid}, 32'd1);
    abort = 1; out_ready = 1; tick;
    abort = 0; out_ready = 0;
    chk("abort_done_busy", {31'd0, busy}, 32'd0);
    chk("abort_done_acc", sum_out, 32'h0);

    // reset mid-job, then start on the first edge out of reset
    start = 1; len = LW'(3); tick; start = 0;
    in_valid = 1; in_data = 32'h40400000; tick; in_valid = 0;
    reset = 0; tick; reset = 1;
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_sum", sum_out, 32'h0);
    vq.delete(); vq.push_back(-7.5); vq.push_back(7.5); vq.push_back(1.5);
    job(0, 0, 0, 0, 0, lat);
    chk("post_rst_sum", last_out, 32'h3FC00000);

    // random jobs: gaps, consumer stalls, stray start pulses
    for (int j = 0; j < 40; j++) begin
      vq.delete();
      n = $urandom_range(12);
      for (int i = 0; i < n; i++)
        vq.push_back(real'($urandom_range(4000)) / 2.0 - 1000.0);
      job(30, 0, $urandom_range(3), 0, 1, lat);
      if (j % 5 == 0) tick;
    end

    repeat (3) tick;
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
